// File: rtl/err_compute_seq.sv
// rtl/err_compute_seq.sv - self-sequenced weighted IR error accumulator with saturating output
module err_compute_seq #(
    parameter int NUM_PAIRS = 4,
    parameter int IR_W      = 12,
    parameter int ERR_W     = 16,
    parameter int SAT       = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        IR_vld,
    input  logic                        err_mode,
    input  logic [NUM_PAIRS*IR_W-1:0]   IR_R,
    input  logic [NUM_PAIRS*IR_W-1:0]   IR_L,
    output logic signed [ERR_W-1:0]     error,
    output logic                        err_vld,
    output logic                        busy
);

    localparam int ACC_W  = IR_W + NUM_PAIRS + 2;
    localparam int IDX_W  = $clog2(2 * NUM_PAIRS);
    localparam int PAIR_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
    localparam int WIDE   = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * NUM_PAIRS - 1);
    localparam logic signed [WIDE-1:0] SAT_MAX =
        {{(WIDE - ERR_W + 1){1'b0}}, {(ERR_W - 1){1'b1}}};
    localparam logic signed [WIDE-1:0] SAT_MIN =
        {{(WIDE - ERR_W + 1){1'b1}}, {(ERR_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t                         r_state;
    logic signed [ACC_W-1:0]        r_acc;
    logic [IDX_W-1:0]               r_idx;
    logic [NUM_PAIRS*IR_W-1:0]      r_snap_r;
    logic [NUM_PAIRS*IR_W-1:0]      r_snap_l;
    logic                           r_mode;
    logic signed [ERR_W-1:0]        r_error;
    logic                           r_err_vld;
    logic                           r_busy;

    logic [PAIR_W-1:0]              w_pair;
    logic [IR_W-1:0]                w_sel;
    logic [ACC_W-1:0]               w_ext;
    logic signed [ACC_W-1:0]        w_term;
    logic signed [ACC_W-1:0]        w_next;
    logic signed [WIDE-1:0]         w_wide;
    logic signed [ERR_W-1:0]        w_result;

    // Even index is the right reading of pair idx/2, odd index the left one.
    assign w_pair = PAIR_W'(r_idx >> 1);
    assign w_sel  = r_idx[0] ? r_snap_l[w_pair*IR_W +: IR_W]
                             : r_snap_r[w_pair*IR_W +: IR_W];
    assign w_ext  = ACC_W'(w_sel);
    assign w_term = r_mode ? w_ext : (w_ext << w_pair);
    assign w_next = r_idx[0] ? (r_acc - w_term) : (r_acc + w_term);

    assign w_wide = WIDE'(r_acc);

    always_comb begin
        w_result = w_wide[ERR_W-1:0];
        if (SAT != 0) begin
            if (w_wide > SAT_MAX) begin
                w_result = SAT_MAX[ERR_W-1:0];
            end else if (w_wide < SAT_MIN) begin
                w_result = SAT_MIN[ERR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_idx     <= '0;
            r_snap_r  <= '0;
            r_snap_l  <= '0;
            r_mode    <= 1'b0;
            r_error   <= '0;
            r_err_vld <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_err_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (IR_vld) begin
                        r_snap_r <= IR_R;
                        r_snap_l <= IR_L;
                        r_mode   <= err_mode;
                        r_acc    <= '0;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_acc <= w_next;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_error   <= w_result;
                    r_err_vld <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign error   = r_error;
    assign err_vld = r_err_vld;
    assign busy    = r_busy;

endmodule

// File: tb/tb_err_compute_seq.sv
// tb/tb_err_compute_seq.sv - scoreboard bench for err_compute_seq (saturating and wrapping instances)
module tb_err_compute_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        IR_vld = 1'b0;
    logic        err_mode = 1'b0;
    logic [47:0] IR_R = '0;
    logic [47:0] IR_L = '0;
    logic [15:0] error_s, error_w;
    logic        err_vld_s, err_vld_w, busy_s, busy_w;

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t        q_s[$];
    exp_t        q_w[$];
    logic [15:0] hold_s = '0;
    logic [15:0] hold_w = '0;
    int          edge_cnt = 0;
    int          last_k = -100;
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;

    err_compute_seq #(.NUM_PAIRS(4), .IR_W(12), .ERR_W(16), .SAT(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .IR_vld(IR_vld), .err_mode(err_mode),
        .IR_R(IR_R), .IR_L(IR_L), .error(error_s), .err_vld(err_vld_s), .busy(busy_s)
    );

    err_compute_seq #(.NUM_PAIRS(4), .IR_W(12), .ERR_W(16), .SAT(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .IR_vld(IR_vld), .err_mode(err_mode),
        .IR_R(IR_R), .IR_L(IR_L), .error(error_w), .err_vld(err_vld_w), .busy(busy_w)
    );

    always #10 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference: signed sum of (R_i - L_i) * weight_i, then clamp or wrap to 16 bits.
    function automatic logic [15:0] model(input logic [47:0] r, input logic [47:0] l,
                                          input logic m, input bit sat);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            s += (int'(r[i*12 +: 12]) - int'(l[i*12 +: 12])) * (m ? 1 : (1 << i));
        end
        if (sat) begin
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
        end
        return s[15:0];
    endfunction

    function automatic logic [47:0] gen();
        logic [47:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i*12 +: 12] = 12'h000;
                1:       v[i*12 +: 12] = 12'hFFF;
                default: v[i*12 +: 12] = 12'($urandom_range(0, 4095));
            endcase
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic vld, input logic bsy, input logic [15:0] err,
                       input bit have, input logic [15:0] head, input logic [15:0] hold,
                       input bit exp_busy);
        logic [15:0] exp_err;
        exp_err = have ? head : hold;
        checks++;
        if (vld !== have) begin
            failures++;
            $display("FAIL %s_err_vld edge=%0d got=%b want=%b", nm, edge_cnt, vld, have);
        end
        checks++;
        if (bsy !== exp_busy) begin
            failures++;
            $display("FAIL %s_busy edge=%0d got=%b want=%b", nm, edge_cnt, bsy, exp_busy);
        end
        checks++;
        if (err !== exp_err) begin
            failures++;
            $display("FAIL %s_error edge=%0d got=%h want=%h", nm, edge_cnt, err, exp_err);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit have_s, have_w, eb;
            have_s = (q_s.size() > 0) && (q_s[0].cyc == edge_cnt);
            have_w = (q_w.size() > 0) && (q_w[0].cyc == edge_cnt);
            eb = (edge_cnt >= last_k) && (edge_cnt <= last_k + 8);
            chk("sat", err_vld_s, busy_s, error_s, have_s, have_s ? q_s[0].val : 16'h0, hold_s, eb);
            chk("wrap", err_vld_w, busy_w, error_w, have_w, have_w ? q_w[0].val : 16'h0, hold_w, eb);
            if (have_s) begin
                hold_s = q_s[0].val;
                void'(q_s.pop_front());
            end
            if (have_w) begin
                hold_w = q_w[0].val;
                void'(q_w.pop_front());
            end
        end
    end

    task automatic drive(input logic vld, input logic [47:0] r, input logic [47:0] l, input logic m);
        @(negedge clk);
        IR_vld = vld;
        IR_R = r;
        IR_L = l;
        err_mode = m;
        @(posedge clk);
        #1;
        if (vld && (edge_cnt >= last_k + 10)) begin
            last_k = edge_cnt;
            q_s.push_back('{val: model(r, l, m, 1'b1), cyc: edge_cnt + 9});
            q_w.push_back('{val: model(r, l, m, 1'b0), cyc: edge_cnt + 9});
        end
        IR_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, gen(), gen(), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        IR_vld = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_s.delete();
        q_w.delete();
        hold_s = '0;
        hold_w = '0;
        last_k = -100;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);

        drive(1'b1, 48'h100, 48'h0, 1'b0);
        idle(11);

        drive(1'b1, 48'h0, {12'h800, 36'h0}, 1'b0);
        idle(10);
        drive(1'b1, {4{12'h100}}, {4{12'h080}}, 1'b1);
        idle(10);

        drive(1'b1, {4{12'hFFF}}, 48'h0, 1'b0);
        idle(10);
        drive(1'b1, 48'h0, {4{12'hFFF}}, 1'b0);
        idle(10);

        drive(1'b1, {12'h010, 12'h020, 12'h030, 12'h040}, {12'h001, 12'h002, 12'h003, 12'h004}, 1'b0);
        idle(2);
        for (int i = 0; i < 7; i++) drive(1'b1, gen(), gen(), 1'b1);
        idle(10);

        drive(1'b1, {4{12'hABC}}, 48'h123, 1'b0);
        idle(9);
        drive(1'b1, 48'h0, {4{12'h321}}, 1'b1);
        idle(10);

        drive(1'b1, {4{12'hFFF}}, 48'h0, 1'b0);
        idle(3);
        do_reset();
        idle(12);
        drive(1'b1, {12'h007, 36'h0}, 48'h005, 1'b0);
        idle(10);

        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 3) == 0), gen(), gen(), 1'($urandom_range(0, 1)));
        end
        idle(12);

        checks++;
        if (q_s.size() != 0 || q_w.size() != 0) begin
            failures++;
            $display("FAIL drain pending_sat=%0d pending_wrap=%0d want=0", q_s.size(), q_w.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/err_compute_seq.md
Name: err_compute_seq

Overview:
- Parametrised, self-sequenced successor to the line-follower error datapath.
- On a valid strobe it snapshots NUM_PAIRS right/left IR readings and walks them one operand per clock.
- It accumulates a signed, position-weighted error: right readings add, left readings subtract, weighted 2^i.
- It delivers a saturated ERR_W-bit result to the PID with a one-cycle valid pulse. No external sel/sub/accum control is needed.

Parameters:
- NUM_PAIRS, 4, number of right/left IR sensor pairs (1..8); pair 0 is innermost.
- IR_W, 12, width of each unsigned IR reading.
- ERR_W, 16, width of the signed error output.
- SAT, 1, 1 = saturate the result to the ERR_W signed range; 0 = truncate to the low ERR_W bits (two's-complement wrap).

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- IR_vld  in  1  start strobe: new readings present on IR_R/IR_L.
- err_mode  in  1  0 = weighted (pair i scaled by 2^i); 1 = unweighted (all weights 1).
- IR_R  in  NUM_PAIRS*IR_W  right readings; pair i occupies bits [i*IR_W +: IR_W].
- IR_L  in  NUM_PAIRS*IR_W  left readings, same packing.
- error  out  ERR_W  signed error result, registered.
- err_vld  out  1  one-cycle pulse: error has just updated.
- busy  out  1  high while a computation is in progress.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, accumulator=0, index=0, error=0, err_vld=0, busy=0. Applies from any state, including mid-ACCUM. An aborted computation never produces err_vld.
- Internal accumulator: signed, ACC_W = IR_W+NUM_PAIRS+2 bits. It cannot overflow for any input.
- FSM states:
  - IDLE: busy=0. If IR_vld=1 at edge k:
    - capture IR_R, IR_L and err_mode into snapshot registers;
    - clear the accumulator and set index=0;
    - go to ACCUM.
    - IR_vld=0 stays in IDLE.
  - ACCUM: busy=1. At each of the edges k+1 .. k+2*NUM_PAIRS, add one term.
    - Term order: R0, L0, R1, L1, ..., R(N-1), L(N-1).
    - Term value = reading << i when err_mode=0, or reading when err_mode=1. It is zero-extended to ACC_W.
    - R terms add; L terms subtract.
    - Go to DONE after the last term (edge k+2*NUM_PAIRS).
  - DONE: busy=1. At edge k+2*NUM_PAIRS+1:
    - error <= result;
    - err_vld <= 1 for exactly one cycle;
    - go to IDLE.
    - busy is 0 in the same cycle err_vld is 1.
- Result:
  - SAT=1: clamp the accumulator to [-2^(ERR_W-1), 2^(ERR_W-1)-1].
  - SAT=0: take accumulator[ERR_W-1:0].
- Latency: err_vld high in the cycle following edge k+2*NUM_PAIRS+1 (cycle 10 after the strobe for the defaults). Throughput is one result per 2*NUM_PAIRS+2 cycles.
- error holds its value between results. It changes only on the DONE edge or on reset.
- IR_vld while busy=1, including during DONE: ignored, not queued. Inputs may change freely after the capture edge; only the snapshot is used.
- IR_vld in the cycle where err_vld=1 (state IDLE): accepted normally, allowing back-to-back operation.
- err_mode changing mid-computation has no effect; the captured value is used.

Test Plan:
1. Defaults, err_mode=0, R0=0x100, all others 0; pulse IR_vld -> error=0x0100. err_vld is a single pulse 2*4+1=9 clocks after the strobe edge. busy is high for 9 cycles.
2. err_mode=0, only L3=0x800 -> error=0xC000 (-16384). Then err_mode=1 with R all 0x100 and L all 0x080 -> error=0x0200.
3. Saturation, SAT=1: R all 0xFFF, L all 0, weighted (+61425) -> error=0x7FFF. L all 0xFFF, R all 0 -> error=0x8000. Same first case with SAT=0 -> error=0xEFF1.
4. Snapshot and ignore: change IR_R/IR_L and err_mode, and pulse IR_vld again, during ACCUM -> result equals the first capture only; exactly one err_vld.
5. Back-to-back: assert IR_vld in the err_vld cycle with new data -> second result 10 cycles later, correct. error holds the first value until then.
6. Reset mid-operation: rst_n=0 for one edge at the 4th ACCUM cycle -> error=0, busy=0, and no err_vld afterwards. The next strobe computes correctly from a cleared accumulator.
